ctlchain_seq: RTL
=================

# ctlchain_seq

Parametrised, sequential successor of the 16-bit MSB-first control chain used in the spintronic adder datapath. Evaluates a ripple control chain over `WIDTH` bits one `SEG`-bit segment per clock, from MSB segment to LSB segment. Supports exact (unbroken chain) and segmented (boundary-injected) modes. Sits between operand staging and the adder core behind valid/ready handshakes.

## Interface
- `WIDTH`, 16: operand and result width; must be an integer multiple of `SEG`.
- `SEG`, 8: bits evaluated per cycle; `NSEG = WIDTH/SEG` ≥ 1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `a`, `b`  in  WIDTH  operands.
- `mode`  in  1  0 = exact, 1 = segmented; sampled at accept.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `s`  out  WIDTH  control vector result.
- `busy`  out  1  high in RUN or DONE.

## Operation
- Cell function: `ctl(a,b,x) = (a&b) | (x&(a|b))`. Bit `i` output `s[i] = ctl(a[i], b[i], x_i)`.
- Chain runs from bit `WIDTH-1` down to 0. `x_{WIDTH-1} = 0`.
- Exact mode: `x_i = s[i+1]` for every `i < WIDTH-1`.
- Segmented mode: same, except for the top bit `t` of each segment `k > 0`, where `x_t = s[WIDTH-1] | s[t+1]`.
- States:
  - IDLE: `in_ready=1`. On `in_valid & in_ready`, latch `a`, `b`, `mode`; set seg index `k=0`; go to RUN.
  - RUN: each cycle compute segment `k`, covering bits `WIDTH-1-k*SEG` down to `WIDTH-SEG-k*SEG`. Write those bits into the result register. Register the segment's lowest output as the chain carry. Register `s[WIDTH-1]` when `k=0`. Increment `k`. After `k=NSEG-1`, go to DONE.
  - DONE: `out_valid=1`, `s` held stable. On `out_valid & out_ready`, go to IDLE.
- Operand and mode registers do not change outside the IDLE accept; input changes during RUN/DONE are ignored.
- `NSEG=1`: RUN lasts one cycle; segmented mode equals exact mode.

## Timing
- Reset (`rst_n=0` at an edge): state IDLE, `in_ready=1`, `out_valid=0`, `busy=0`, `s=0`, `k=0`, chain registers 0. Reset in RUN or DONE aborts and discards the result.
- Accept at edge E0. Segments are computed at edges E1..E_NSEG. `out_valid` is high from E_NSEG, i.e. `NSEG` cycles after accept.
- `in_ready` is low from E0 until the edge after the output handshake. Earliest next accept is E_{NSEG+2}; no overlap of operations.
- `out_valid` stays high and `s` stays constant until `out_ready`; there is no timeout.
- `s` keeps the last result in IDLE. Partially written bits are not observable: `s` is updated only at the transition into DONE, from an internal shadow register.

## Configuration
- `CTLCHAIN_SEGMODE_EN` defined: segmented mode available as described.
- Not defined: `mode` is ignored; the block always runs exact mode and the boundary-OR logic is removed.

## Test plan
- WIDTH=16, SEG=8, exact: `a=16'h8000`, `b=16'hFFFF` → `s=16'hFFFF`, `out_valid` 2 cycles after accept.
- Exact: `a=16'h8000`, `b=16'h80FF` → `s=16'h8000`. Same operands with `mode=1` and the macro defined → `s=16'h80FF`. Macro undefined → `16'h8000`.
- `a=16'hFFFF`, `b=0`, either mode → `s=16'h0000`. `a=b=16'h8000` → `s=16'h8000`.
- Backpressure: hold `out_ready=0` for 5 cycles after `out_valid` → `s` stable, `in_ready=0`. Release → IDLE and `in_ready=1` the next cycle. A new accept is taken no earlier.
- Reset mid-RUN (WIDTH=32, SEG=8, `rst_n=0` at k=2) → next cycle `out_valid=0`, `busy=0`, `in_ready=1`, `s=0`. A subsequent operation is correct.
- Random sweep, WIDTH∈{8,16,32}, SEG∈{1,4,8}, random `out_ready` → `s` matches the bit-level reference model for the latched mode.

Source files
------------

// File: rtl/ctlchain_seq.sv
// ctlchain_seq: sequential MSB-first control chain.
// Evaluates ctl(a,b,x) = (a&b) | (x&(a|b)) over WIDTH bits, one SEG-bit
// segment per clock, from the most significant segment down to the least.
// Results are built in a shadow register and published to s on entry to DONE.
// Optional feature macro: CTLCHAIN_SEGMODE_EN enables segmented mode
// (boundary OR of the chain's top output into each lower segment's top bit).
// Without it, mode is ignored and the chain is always exact.
`timescale 1ns/1ps

module ctlchain_seq #(
  parameter int WIDTH = 16,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             busy
);

  localparam int NSEG = WIDTH / SEG;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSEG - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [KW-1:0]    k;
  logic             carry_q;   // lowest output of the previous segment
  logic [WIDTH-1:0] shadow;    // partially built result, never visible on s

`ifdef CTLCHAIN_SEGMODE_EN
  logic             mode_q;
  logic             msb_q;     // s[WIDTH-1], captured while evaluating segment 0
`else
  logic             unused_mode;
  assign unused_mode = mode;
`endif

  logic [SEG-1:0]   seg_a;
  logic [SEG-1:0]   seg_b;
  logic [SEG-1:0]   seg_s;
  logic             seg_x;
  logic             ripple_x;
  logic [WIDTH-1:0] shadow_next;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  // Select the current segment's operands and chain input, ripple it, and merge it into the shadow.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    seg_a       = '0;
    seg_b       = '0;
    shadow_next = shadow;
    for (int j = 0; j < NSEG; j++) begin
      if (k == KW'(j)) begin
        seg_a = a_q[WIDTH-1-j*SEG -: SEG];
        seg_b = b_q[WIDTH-1-j*SEG -: SEG];
      end
    end

    if (k == '0) begin
      seg_x = 1'b0;
    end else begin
`ifdef CTLCHAIN_SEGMODE_EN
      seg_x = carry_q | (mode_q & msb_q);
`else
      seg_x = carry_q;
`endif
    end

    ripple_x = seg_x;
    seg_s    = '0;
    for (int i = SEG - 1; i >= 0; i--) begin
      seg_s[i] = (seg_a[i] & seg_b[i]) | (ripple_x & (seg_a[i] | seg_b[i]));
      ripple_x = seg_s[i];
    end

    for (int j = 0; j < NSEG; j++) begin
      if (k == KW'(j)) begin
        shadow_next[WIDTH-1-j*SEG -: SEG] = seg_s;
      end
    end
  end

  // Handshake FSM, operand capture and per-segment state update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k       <= '0;
      carry_q <= 1'b0;
      shadow  <= '0;
      s       <= '0;
`ifdef CTLCHAIN_SEGMODE_EN
      mode_q  <= 1'b0;
      msb_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
`ifdef CTLCHAIN_SEGMODE_EN
            mode_q <= mode;
`endif
            k      <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          shadow  <= shadow_next;
          carry_q <= seg_s[0];
`ifdef CTLCHAIN_SEGMODE_EN
          if (k == '0) msb_q <= seg_s[SEG-1];
`endif
          if (k == K_LAST) begin
            s     <= shadow_next;
            state <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
